// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for the fifo_sync_snap FIFO.
//   cnt_w(m)    - width of an occupancy counter that can hold 0..m
//   ptr_w(m)    - width of a pointer that addresses entries 0..m-1
//   fifo_stat_t - bundle of the FIFO occupancy and error flags
package fifo_pkg;

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    function automatic int ptr_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic ovf;
        logic udf;
    } fifo_stat_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-M pointer with increment enable and synchronous clear.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset (pointer -> 0)
//   clr_i  - synchronous clear (pointer -> 0), wins over inc_i
//   inc_i  - advance by one, wrapping from M-1 to 0
//   ptr_o  - current pointer value
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int M = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [ptr_w(M)-1:0] ptr_o
);

    localparam int              PW   = ptr_w(M);
    localparam logic [PW-1:0]   LAST = PW'(M - 1);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            // Explicit wrap so non-power-of-two depths work.
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_snap.sv
// fifo_sync_snap: single-clock first-word-fall-through FIFO with occupancy
// flags, sticky overflow/underflow, and an optional snapshot window.
// Optional feature macro: FIFO_SYNC_SNAP_WIN_EN adds win_o / win_vld_o.
// Ports:
//   clk_i, rst_i (async, active-high), clr_i (synchronous flush)
//   wr_en_i / wr_data_i  - push request and data
//   rd_en_i / rd_data_o  - pop request and oldest entry (0 when empty)
//   full_o, empty_o, afull_o (count>=AF_LVL), aempty_o (count<=AE_LVL)
//   count_o              - occupancy 0..M
//   ovf_o, udf_o         - sticky overflow / underflow until clr_i or rst_i
//   win_o, win_vld_o     - entry k (oldest first) at win_o[k*N +: N]; valid
//                          bit set for k < count_o, invalid slots read 0
module fifo_sync_snap
    import fifo_pkg::*;
#(
    parameter int N      = 32,
    parameter int M      = 16,
    parameter int AF_LVL = M - 2,
    parameter int AE_LVL = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                wr_en_i,
    input  logic [N-1:0]        wr_data_i,
    input  logic                rd_en_i,
    output logic [N-1:0]        rd_data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                afull_o,
    output logic                aempty_o,
    output logic [cnt_w(M)-1:0] count_o,
    output logic                ovf_o,
    output logic                udf_o
`ifdef FIFO_SYNC_SNAP_WIN_EN
    ,
    output logic [M*N-1:0]      win_o,
    output logic [M-1:0]        win_vld_o
`endif
);

    localparam int            CW     = cnt_w(M);
    localparam int            PW     = ptr_w(M);
    localparam logic [CW-1:0] FULL_C = CW'(M);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LVL);

    // Storage is deliberately not reset; validity comes from count_q.
    logic [N-1:0]  mem_q [M];
    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          push_acc, pop_acc;
    fifo_stat_t    stat;

    always_comb begin
        stat.full   = (count_q == FULL_C);
        stat.empty  = (count_q == '0);
        stat.afull  = (count_q >= AF_C);
        stat.aempty = (count_q <= AE_C);
        stat.ovf    = ovf_q;
        stat.udf    = udf_q;
    end

    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    // A flush overrides both requests.
    assign pop_acc  = rd_en_i & ~stat.empty & ~clr_i;
    assign push_acc = wr_en_i & (~stat.full | pop_acc) & ~clr_i;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q | (wr_en_i & stat.full & ~pop_acc);
        udf_d   = udf_q | (rd_en_i & stat.empty);
        if (clr_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (push_acc && !pop_acc) begin
            count_d = count_q + 1'b1;
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[wptr] <= wr_data_i;
        end
    end

    fifo_wrap_ptr #(.M(M)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (pop_acc),
        .ptr_o (rptr)
    );

    fifo_wrap_ptr #(.M(M)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (push_acc),
        .ptr_o (wptr)
    );

    // Empty forces zero so stale storage never leaks out (also on reset).
    assign rd_data_o = stat.empty ? '0 : mem_q[rptr];
    assign full_o    = stat.full;
    assign empty_o   = stat.empty;
    assign afull_o   = stat.afull;
    assign aempty_o  = stat.aempty;
    assign ovf_o     = stat.ovf;
    assign udf_o     = stat.udf;
    assign count_o   = count_q;

`ifdef FIFO_SYNC_SNAP_WIN_EN
    localparam logic [PW:0] M_P = (PW + 1)'(M);

    logic [PW:0] widx;

    // Rotate storage so slot k shows the entry k places behind the read
    // pointer. rptr + k < 2*M, so a single conditional subtract is the modulo.
    always_comb begin
        win_o     = '0;
        win_vld_o = '0;
        widx      = '0;
        for (int k = 0; k < M; k++) begin
            widx = {1'b0, rptr} + (PW + 1)'(k);
            if (widx >= M_P) begin
                widx = widx - M_P;
            end
            if (CW'(k) < count_q) begin
                win_vld_o[k]     = 1'b1;
                win_o[k*N +: N]  = mem_q[widx[PW-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_snap.sv
// Bench for fifo_sync_snap: a queue-based reference model is compared with two
// instances (M=16/N=32 and M=5/N=8) on every falling clock edge, with directed
// scenarios carrying literal expectations plus randomized traffic.
module tb_fifo_sync_snap;

    localparam int N16 = 32;
    localparam int M16 = 16;
    localparam int N5  = 8;
    localparam int M5  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // M=16 instance signals
    logic        clr16 = 1'b0, wr16 = 1'b0, rd16 = 1'b0;
    logic [31:0] d16 = '0;
    logic [31:0] rdata16;
    logic        full16, empty16, af16, ae16, ovf16, udf16;
    logic [4:0]  cnt16;
`ifdef FIFO_SYNC_SNAP_WIN_EN
    logic [M16*N16-1:0] win16;
    logic [M16-1:0]     wv16;
`endif

    // M=5 instance signals
    logic        clr5 = 1'b0, wr5 = 1'b0, rd5 = 1'b0;
    logic [7:0]  d5 = '0;
    logic [7:0]  rdata5;
    logic        full5, empty5, af5, ae5, ovf5, udf5;
    logic [2:0]  cnt5;
`ifdef FIFO_SYNC_SNAP_WIN_EN
    logic [M5*N5-1:0] win5;
    logic [M5-1:0]    wv5;
`endif

    fifo_sync_snap #(.N(N16), .M(M16)) u16 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr16),
        .wr_en_i(wr16), .wr_data_i(d16), .rd_en_i(rd16), .rd_data_o(rdata16),
        .full_o(full16), .empty_o(empty16), .afull_o(af16), .aempty_o(ae16),
        .count_o(cnt16), .ovf_o(ovf16), .udf_o(udf16)
`ifdef FIFO_SYNC_SNAP_WIN_EN
        , .win_o(win16), .win_vld_o(wv16)
`endif
    );

    fifo_sync_snap #(.N(N5), .M(M5)) u5 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr5),
        .wr_en_i(wr5), .wr_data_i(d5), .rd_en_i(rd5), .rd_data_o(rdata5),
        .full_o(full5), .empty_o(empty5), .afull_o(af5), .aempty_o(ae5),
        .count_o(cnt5), .ovf_o(ovf5), .udf_o(udf5)
`ifdef FIFO_SYNC_SNAP_WIN_EN
        , .win_o(win5), .win_vld_o(wv5)
`endif
    );

    // Reference model: FIFO contents as queues, oldest at index 0.
    logic [31:0] q16[$];
    logic [7:0]  q5[$];
    bit m_ovf16 = 0, m_udf16 = 0, m_ovf5 = 0, m_udf5 = 0;
    bit fl16, em16, po16, pu16, fl5, em5, po5, pu5;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q16.delete(); q5.delete();
            m_ovf16 = 0; m_udf16 = 0; m_ovf5 = 0; m_udf5 = 0;
        end else begin
            if (clr16) begin
                q16.delete(); m_ovf16 = 0; m_udf16 = 0;
            end else begin
                fl16 = (q16.size() == M16);
                em16 = (q16.size() == 0);
                po16 = rd16 && !em16;
                pu16 = wr16 && (!fl16 || po16);
                if (rd16 && em16) m_udf16 = 1;
                if (wr16 && fl16 && !po16) m_ovf16 = 1;
                if (po16) void'(q16.pop_front());
                if (pu16) q16.push_back(d16);
            end
            if (clr5) begin
                q5.delete(); m_ovf5 = 0; m_udf5 = 0;
            end else begin
                fl5 = (q5.size() == M5);
                em5 = (q5.size() == 0);
                po5 = rd5 && !em5;
                pu5 = wr5 && (!fl5 || po5);
                if (rd5 && em5) m_udf5 = 1;
                if (wr5 && fl5 && !po5) m_ovf5 = 1;
                if (po5) void'(q5.pop_front());
                if (pu5) q5.push_back(d5);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cnt16",   64'(cnt16),   64'(q16.size()));
        chk("rdata16", 64'(rdata16), 64'((q16.size() > 0) ? q16[0] : 32'd0));
        chk("full16",  64'(full16),  64'(q16.size() == M16));
        chk("empty16", 64'(empty16), 64'(q16.size() == 0));
        chk("afull16", 64'(af16),    64'(q16.size() >= M16 - 2));
        chk("aempty16",64'(ae16),    64'(q16.size() <= 2));
        chk("ovf16",   64'(ovf16),   64'(m_ovf16));
        chk("udf16",   64'(udf16),   64'(m_udf16));
        chk("cnt5",    64'(cnt5),    64'(q5.size()));
        chk("rdata5",  64'(rdata5),  64'((q5.size() > 0) ? q5[0] : 8'd0));
        chk("full5",   64'(full5),   64'(q5.size() == M5));
        chk("empty5",  64'(empty5),  64'(q5.size() == 0));
        chk("afull5",  64'(af5),     64'(q5.size() >= M5 - 2));
        chk("aempty5", 64'(ae5),     64'(q5.size() <= 2));
        chk("ovf5",    64'(ovf5),    64'(m_ovf5));
        chk("udf5",    64'(udf5),    64'(m_udf5));
`ifdef FIFO_SYNC_SNAP_WIN_EN
        for (int k = 0; k < M16; k++) begin
            chk("win16", 64'(win16[k*N16 +: N16]), 64'((k < q16.size()) ? q16[k] : 32'd0));
            chk("wvld16", 64'(wv16[k]), 64'(k < q16.size()));
        end
        for (int k = 0; k < M5; k++) begin
            chk("win5", 64'(win5[k*N5 +: N5]), 64'((k < q5.size()) ? q5[k] : 8'd0));
            chk("wvld5", 64'(wv5[k]), 64'(k < q5.size()));
        end
`endif
    end

    // Apply one cycle of requests; returns 2 time units after the edge.
    task automatic step16(input logic w, input logic r, input logic [31:0] d, input logic c);
        wr16 = w; rd16 = r; d16 = d; clr16 = c;
        @(posedge clk); #2;
        wr16 = 1'b0; rd16 = 1'b0; clr16 = 1'b0;
    endtask

    task automatic step5(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr5 = w; rd5 = r; d5 = d; clr5 = c;
        @(posedge clk); #2;
        wr5 = 1'b0; rd5 = 1'b0; clr5 = 1'b0;
    endtask

    logic        rw, rr, rc;
    logic [7:0]  vals5 [26];

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_cnt",   64'(cnt16),   64'd0);
        chk("rst_empty", 64'(empty16), 64'd1);
        chk("rst_rdata", 64'(rdata16), 64'd0);

        // Fill 0x1..0x10 with no pops.
        for (int i = 1; i <= 16; i++) begin
            step16(1'b1, 1'b0, 32'(i), 1'b0);
            if (i == 13) chk("afull_at13", 64'(af16), 64'd0);
            if (i == 14) chk("afull_at14", 64'(af16), 64'd1);
        end
        chk("full_at16",  64'(full16),  64'd1);
        chk("cnt_at16",   64'(cnt16),   64'd16);
        chk("head_at16",  64'(rdata16), 64'h1);

        // Push into full FIFO: dropped, overflow set.
        step16(1'b1, 1'b0, 32'hAA, 1'b0);
        chk("ovf_drop", 64'(ovf16), 64'd1);
        chk("cnt_drop", 64'(cnt16), 64'd16);
        for (int i = 1; i <= 16; i++) begin
            chk("pop_order", 64'(rdata16), 64'(i));
            step16(1'b0, 1'b1, 32'd0, 1'b0);
        end
        chk("empty_after", 64'(empty16), 64'd1);
        chk("ovf_sticky",  64'(ovf16),   64'd1);

        // Flush overrides a simultaneous push and clears sticky flags.
        step16(1'b1, 1'b0, 32'h99, 1'b1);
        chk("clr_cnt", 64'(cnt16), 64'd0);
        chk("clr_ovf", 64'(ovf16), 64'd0);

        // Push and pop together while full.
        for (int i = 1; i <= 16; i++) step16(1'b1, 1'b0, 32'(i), 1'b0);
        step16(1'b1, 1'b1, 32'hBB, 1'b0);
        chk("fullpp_head", 64'(rdata16), 64'h2);
        chk("fullpp_cnt",  64'(cnt16),   64'd16);
        chk("fullpp_ovf",  64'(ovf16),   64'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("last_bb", 64'(rdata16), 64'hBB);
            step16(1'b0, 1'b1, 32'd0, 1'b0);
        end

        // Push and pop together while empty: no bypass, underflow set.
        step16(1'b1, 1'b1, 32'h55, 1'b0);
        chk("emptypp_udf",  64'(udf16),   64'd1);
        chk("emptypp_cnt",  64'(cnt16),   64'd1);
        chk("emptypp_data", 64'(rdata16), 64'h55);

        // Randomized traffic: fill-biased then drain-biased, rare flushes.
        step16(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            rw = ($urandom_range(0, 99) < ((i < 200) ? 75 : 35));
            rr = ($urandom_range(0, 99) < ((i < 200) ? 35 : 75));
            rc = ($urandom_range(0, 99) < 2);
            step16(rw, rr, $urandom(), rc);
        end

        // Asynchronous reset between edges with 7 entries.
        step16(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 7; i++) step16(1'b1, 1'b0, 32'(100 + i), 1'b0);
        chk("pre_rst_cnt", 64'(cnt16), 64'd7);
        rst = 1'b1;
        #1;
        chk("arst_cnt",   64'(cnt16),   64'd0);
        chk("arst_empty", 64'(empty16), 64'd1);
        chk("arst_ae",    64'(ae16),    64'd1);
        chk("arst_full",  64'(full16),  64'd0);
        chk("arst_af",    64'(af16),    64'd0);
        chk("arst_rdata", 64'(rdata16), 64'd0);
`ifdef FIFO_SYNC_SNAP_WIN_EN
        chk("arst_wvld",  64'(wv16),    64'd0);
`endif
        @(posedge clk); #2;
        rst = 1'b0;
        step16(1'b1, 1'b0, 32'h77, 1'b0);
        chk("post_rst_data", 64'(rdata16), 64'h77);
        chk("post_rst_cnt",  64'(cnt16),   64'd1);

        // M=5: hold occupancy at 3 for 23 push/pop cycles so pointers wrap.
        for (int i = 0; i < 26; i++) vals5[i] = 8'($urandom());
        for (int i = 0; i < 3; i++) step5(1'b1, 1'b0, vals5[i], 1'b0);
        for (int i = 3; i < 26; i++) step5(1'b1, 1'b1, vals5[i], 1'b0);
        chk("m5_cnt",  64'(cnt5),   64'd3);
        chk("m5_head", 64'(rdata5), 64'(vals5[23]));
`ifdef FIFO_SYNC_SNAP_WIN_EN
        chk("m5_wvld", 64'(wv5),    64'b00111);
        chk("m5_win2", 64'(win5[2*N5 +: N5]), 64'(vals5[25]));
`endif
        for (int i = 0; i < 300; i++) begin
            rw = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 50);
            rc = ($urandom_range(0, 99) < 2);
            step5(rw, rr, 8'($urandom()), rc);
        end

        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
